// File: rtl/multicycle_controller_if.sv
// Memory request/ready handshake between the multi-cycle controller and the memory port.
// The master side is the controller; the slave side is the memory.
interface multicycle_controller_if;
  logic MemReq;
  logic MemWrite;
  logic AdrSrc;
  logic MemReady;

  modport master (
    output MemReq,
    output MemWrite,
    output AdrSrc,
    input  MemReady
  );

  modport slave (
    input  MemReq,
    input  MemWrite,
    input  AdrSrc,
    output MemReady
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory handshake.
// Optional memory wait timeout when CTRL_MEM_TIMEOUT_EN is defined.
module multicycle_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter bit          ILLEGAL_TRAP   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  multicycle_controller_if.master mem,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Negative,
  input  logic       Carry,
  input  logic       Overflow,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       Fault
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpAluR   = 7'b0110011;
  localparam logic [6:0] OpAluI   = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR,
    StExecI, StAluWb, StBranch, StJump, StLink, StLui, StFault
  } state_e;

  state_e state_q;
  logic   timed_out;
  logic   waiting;
  logic [3:0] funct_ctl;
  logic [2:0] imm_dec;
  logic       branch_taken;

  assign waiting = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;

  // Any cycle outside a wait, or one with MemReady, restarts the count for the next access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (waiting && !mem.MemReady) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign timed_out = waiting && !mem.MemReady && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle:   state_q <= StFetch;
        StFetch: begin
          if (mem.MemReady)   state_q <= StDecode;
          else if (timed_out) state_q <= StFault;
        end
        StDecode: begin
          case (op)
            OpLoad, OpStore: state_q <= StMemAdr;
            OpAluR:          state_q <= StExecR;
            OpAluI:          state_q <= StExecI;
            OpBranch:        state_q <= StBranch;
            OpJal, OpJalr:   state_q <= StJump;
            OpLui:           state_q <= StLui;
            OpAuipc:         state_q <= StAluWb;
            default:         state_q <= ILLEGAL_TRAP ? StFault : StFetch;
          endcase
        end
        StMemAdr: state_q <= op[5] ? StMemWrite : StMemRead;
        StMemRead: begin
          if (mem.MemReady)   state_q <= StMemWb;
          else if (timed_out) state_q <= StFault;
        end
        StMemWrite: begin
          if (mem.MemReady)   state_q <= StFetch;
          else if (timed_out) state_q <= StFault;
        end
        StExecR, StExecI: state_q <= StAluWb;
        StJump:           state_q <= StLink;
        StMemWb, StAluWb, StBranch, StLink, StLui: state_q <= StFetch;
        StFault:          state_q <= StFault;
        default:          state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    imm_dec = 3'b000;
    case (op)
      OpStore:         imm_dec = 3'b001;
      OpBranch:        imm_dec = 3'b010;
      OpJal:           imm_dec = 3'b011;
      OpLui, OpAuipc:  imm_dec = 3'b100;
      default:         imm_dec = 3'b000;
    endcase
  end

  always_comb begin
    funct_ctl = AluAdd;
    case (funct3)
      3'b000:  funct_ctl = (op[5] & funct7b5) ? AluSub : AluAdd;
      3'b001:  funct_ctl = 4'b0111;
      3'b010:  funct_ctl = 4'b0101;
      3'b011:  funct_ctl = 4'b0110;
      3'b100:  funct_ctl = 4'b0100;
      3'b101:  funct_ctl = funct7b5 ? 4'b1001 : 4'b1000;
      3'b110:  funct_ctl = 4'b0011;
      default: funct_ctl = 4'b0010;
    endcase
  end

  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = Zero;
      3'b001:  branch_taken = ~Zero;
      3'b100:  branch_taken = Negative ^ Overflow;
      3'b101:  branch_taken = ~(Negative ^ Overflow);
      3'b110:  branch_taken = ~Carry;
      3'b111:  branch_taken = Carry;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    mem.MemReq   = 1'b0;
    mem.MemWrite = 1'b0;
    mem.AdrSrc   = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ResultSrc    = 2'b00;
    ALUControl   = AluAdd;
    Fault        = 1'b0;
    // Reset lands in IDLE, where every output including ImmSrc must read 0.
    ImmSrc       = (state_q == StIdle) ? 3'b000 : imm_dec;
    case (state_q)
      StFetch: begin
        mem.MemReq = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        IRWrite    = mem.MemReady;
        PCWrite    = mem.MemReady;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StMemRead: begin
        mem.MemReq = 1'b1;
        mem.AdrSrc = 1'b1;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      StMemWrite: begin
        mem.MemReq   = 1'b1;
        mem.MemWrite = 1'b1;
        mem.AdrSrc   = 1'b1;
      end
      StExecR: begin
        ALUSrcA    = 2'b10;
        ALUControl = funct_ctl;
      end
      StExecI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = funct_ctl;
      end
      StAluWb: RegWrite = 1'b1;
      StBranch: begin
        ALUSrcA    = 2'b10;
        ALUControl = AluSub;
        PCWrite    = branch_taken;
      end
      StJump: begin
        PCWrite = 1'b1;
        // JAL takes OldPC+imm already in ALUOut; JALR computes A+imm this cycle.
        if (op == OpJalr) begin
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
        end
      end
      StLink: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        RegWrite  = 1'b1;
      end
      StLui: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
      StFault: Fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: two instances (ILLEGAL_TRAP=1 and 0) share stimulus.
// Output vector order: MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,SrcA,SrcB,Result,Imm,ALU,Fault.
module tb_multicycle_controller;
  localparam int unsigned TimeoutCycles = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_ready = 1'b1;
  logic [6:0] op = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0, negative = 1'b0, carry = 1'b0, overflow = 1'b0;

  logic       irw_a, pcw_a, rw_a, fault_a, irw_b, pcw_b, rw_b, fault_b;
  logic [1:0] sa_a, sb_a, rs_a, sa_b, sb_b, rs_b;
  logic [2:0] imm_a, imm_b;
  logic [3:0] alu_a, alu_b;

  int checks = 0;
  int failures = 0;
  logic [19:0] sbq_a[$];
  logic [19:0] sbq_b[$];
  logic [3:0]  r_alu[8];

  always #5 clk = ~clk;

  multicycle_controller_if mif_a ();
  multicycle_controller_if mif_b ();
  assign mif_a.MemReady = mem_ready;
  assign mif_b.MemReady = mem_ready;

  multicycle_controller #(.TIMEOUT_CYCLES(TimeoutCycles), .ILLEGAL_TRAP(1'b1)) u_dut (
    .clk(clk), .reset(reset), .mem(mif_a), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(zero), .Negative(negative), .Carry(carry), .Overflow(overflow),
    .IRWrite(irw_a), .PCWrite(pcw_a), .RegWrite(rw_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a),
    .ResultSrc(rs_a), .ImmSrc(imm_a), .ALUControl(alu_a), .Fault(fault_a)
  );

  multicycle_controller #(.TIMEOUT_CYCLES(TimeoutCycles), .ILLEGAL_TRAP(1'b0)) u_dut_nop (
    .clk(clk), .reset(reset), .mem(mif_b), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(zero), .Negative(negative), .Carry(carry), .Overflow(overflow),
    .IRWrite(irw_b), .PCWrite(pcw_b), .RegWrite(rw_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b),
    .ResultSrc(rs_b), .ImmSrc(imm_b), .ALUControl(alu_b), .Fault(fault_b)
  );

  wire [19:0] outs_a = {mif_a.MemReq, mif_a.MemWrite, mif_a.AdrSrc, irw_a, pcw_a, rw_a,
                        sa_a, sb_a, rs_a, imm_a, alu_a, fault_a};
  wire [19:0] outs_b = {mif_b.MemReq, mif_b.MemWrite, mif_b.AdrSrc, irw_b, pcw_b, rw_b,
                        sa_b, sb_b, rs_b, imm_b, alu_b, fault_b};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] ov(input logic mreq, mw, adr, irw, pcw, rw,
                                     input logic [1:0] sa, sb, rs, input logic [2:0] imm,
                                     input logic [3:0] alu, input logic flt);
    return {mreq, mw, adr, irw, pcw, rw, sa, sb, rs, imm, alu, flt};
  endfunction

  function automatic logic [19:0] fetch_e(input logic rdy, input logic [2:0] imm);
    return ov(1, 0, 0, rdy, rdy, 0, 2'b00, 2'b10, 2'b10, imm, 4'b0000, 0);
  endfunction

  function automatic logic [19:0] decode_e(input logic [2:0] imm);
    return ov(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, imm, 4'b0000, 0);
  endfunction

  function automatic logic bcond(input logic [2:0] f3, input logic z, n, c, v);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n != v;
      3'b101:  return n == v;
      3'b110:  return !c;
      3'b111:  return c;
      default: return 1'b0;
    endcase
  endfunction

  // Push expectations as the cycle's stimulus is applied; pop and compare on the falling edge.
  task automatic cyc2(input string tag, input logic rdy, input logic [19:0] ea,
                      input logic [19:0] eb);
    mem_ready = rdy;
    sbq_a.push_back(ea);
    sbq_b.push_back(eb);
    @(negedge clk);
    check_val({tag, "_trap"}, 32'(outs_a), 32'(sbq_a.pop_front()));
    check_val({tag, "_nop"}, 32'(outs_b), 32'(sbq_b.pop_front()));
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic rdy, input logic [19:0] e);
    cyc2(tag, rdy, e, e);
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check_val("reset_trap", 32'(outs_a), 32'd0);
    check_val("reset_nop", 32'(outs_b), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("idle", 1'b1, 20'd0);
  endtask

  task automatic fetch_decode(input logic [2:0] imm);
    cyc("fetch", 1'b1, fetch_e(1'b1, imm));
    cyc("decode", 1'b1, decode_e(imm));
  endtask

  task automatic run_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic [3:0] alu);
    set_instr(o, f3, f7);
    fetch_decode(3'b000);
    cyc(o[5] ? "execr" : "execi", 1'b1,
        ov(0, 0, 0, 0, 0, 0, 2'b10, o[5] ? 2'b00 : 2'b01, 2'b00, 3'b000, alu, 0));
    cyc("aluwb", 1'b1, ov(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 0));
  endtask

  initial begin
    logic [2:0] bf3[7];
    logic [3:0] fl[2];
    r_alu = '{4'b0000, 4'b0111, 4'b0101, 4'b0110, 4'b0100, 4'b1000, 4'b0011, 4'b0010};
    bf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
    fl = '{4'b1000, 4'b0110};  // {Z,N,C,V}
    @(posedge clk);
    #1;
    do_reset();

    for (int f = 0; f < 8; f++) run_alu(7'b0110011, 3'(f), 1'b0, r_alu[f]);
    run_alu(7'b0110011, 3'b000, 1'b1, 4'b0001);
    run_alu(7'b0110011, 3'b101, 1'b1, 4'b1001);
    run_alu(7'b0010011, 3'b000, 1'b1, 4'b0000);
    run_alu(7'b0010011, 3'b101, 1'b1, 4'b1001);
    run_alu(7'b0010011, 3'b100, 1'b0, 4'b0100);

    // lw with three wait cycles in MEMREAD
    set_instr(7'b0000011, 3'b010, 1'b0);
    fetch_decode(3'b000);
    cyc("memadr", 1'b1, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 4'b0000, 0));
    for (int i = 0; i < 4; i++)
      cyc("memread", i == 3, ov(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 0));
    cyc("memwb", 1'b1, ov(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 3'b000, 4'b0000, 0));

    // sw with one fetch wait and one write wait
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc("fetch_wait", 1'b0, fetch_e(1'b0, 3'b001));
    fetch_decode(3'b001);
    cyc("memadr_s", 1'b0, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b001, 4'b0000, 0));
    cyc("memwrite", 1'b0, ov(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 4'b0000, 0));
    cyc("memwrite", 1'b1, ov(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 4'b0000, 0));

    for (int b = 0; b < 7; b++) begin
      for (int p = 0; p < 2; p++) begin
        set_instr(7'b1100011, bf3[b], 1'b0);
        {zero, negative, carry, overflow} = fl[p];
        fetch_decode(3'b010);
        cyc($sformatf("branch_f3_%0d_p%0d", bf3[b], p), 1'b1,
            ov(0, 0, 0, 0, bcond(bf3[b], fl[p][3], fl[p][2], fl[p][1], fl[p][0]), 0,
               2'b10, 2'b00, 2'b00, 3'b010, 4'b0001, 0));
      end
    end

    set_instr(7'b1101111, 3'b000, 1'b0);
    fetch_decode(3'b011);
    cyc("jal_jump", 1'b1, ov(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b011, 4'b0000, 0));
    cyc("jal_link", 1'b1, ov(0, 0, 0, 0, 0, 1, 2'b01, 2'b10, 2'b10, 3'b011, 4'b0000, 0));
    set_instr(7'b1100111, 3'b000, 1'b0);
    fetch_decode(3'b000);
    cyc("jalr_jump", 1'b1, ov(0, 0, 0, 0, 1, 0, 2'b10, 2'b01, 2'b10, 3'b000, 4'b0000, 0));
    cyc("jalr_link", 1'b1, ov(0, 0, 0, 0, 0, 1, 2'b01, 2'b10, 2'b10, 3'b000, 4'b0000, 0));
    set_instr(7'b0110111, 3'b000, 1'b0);
    fetch_decode(3'b100);
    cyc("lui", 1'b1, ov(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b11, 3'b100, 4'b0000, 0));
    set_instr(7'b0010111, 3'b000, 1'b0);
    fetch_decode(3'b100);
    cyc("auipc_wb", 1'b1, ov(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b100, 4'b0000, 0));

    set_instr(7'b0110011, 3'b000, 1'b0);
`ifdef CTRL_MEM_TIMEOUT_EN
    // Ready in the final allowed cycle still completes the fetch.
    for (int i = 0; i < 3; i++) cyc("fetch_wait", 1'b0, fetch_e(1'b0, 3'b000));
    cyc("fetch_last", 1'b1, fetch_e(1'b1, 3'b000));
    cyc("decode", 1'b1, decode_e(3'b000));
    cyc("execr", 1'b1, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000, 4'b0000, 0));
    cyc("aluwb", 1'b1, ov(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 0));
    for (int i = 0; i < 4; i++) cyc("fetch_to", 1'b0, fetch_e(1'b0, 3'b000));
    for (int i = 0; i < 3; i++)
      cyc("timeout_fault", 1'b0, ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1));
    do_reset();
`else
    for (int i = 0; i < 20; i++) cyc("fetch_wait", 1'b0, fetch_e(1'b0, 3'b000));
    cyc("fetch_late", 1'b1, fetch_e(1'b1, 3'b000));
    cyc("decode", 1'b1, decode_e(3'b000));
    cyc("execr", 1'b1, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000, 4'b0000, 0));
    cyc("aluwb", 1'b1, ov(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 0));
`endif

    // Illegal opcode: trap instance sticks in FAULT, the other loops FETCH/DECODE.
    set_instr(7'b0000000, 3'b000, 1'b0);
    fetch_decode(3'b000);
    for (int i = 0; i < 20; i++)
      cyc2("illegal", 1'b1, ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1),
           (i % 2 == 0) ? fetch_e(1'b1, 3'b000) : decode_e(3'b000));
    do_reset();

    // Reset in the middle of a load wait aborts immediately.
    set_instr(7'b0000011, 3'b010, 1'b0);
    fetch_decode(3'b000);
    cyc("memadr", 1'b1, ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 4'b0000, 0));
    for (int i = 0; i < 2; i++)
      cyc("memread", 1'b0, ov(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 0));
    do_reset();
    run_alu(7'b0110011, 3'b000, 1'b0, 4'b0000);

    check_val("sb_empty", 32'(sbq_a.size() + sbq_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
